// File: rtl/pixel_feed_controller.sv
`default_nettype none
// ============================================================================
// Module   : pixel_feed_controller
// Purpose  : Buffers HPS-written pixels in a small FIFO and releases them one
//            at a time to the facial detector using its ready /
//            end_recieve_pixel handshake. Counts pixels per frame, stops after
//            a full frame and re-arms on the detector's end-of-frame pulse.
// Ports    : clk                   - system clock, rising edge
//            reset                 - synchronous, active-low reset
//            i_start               - one-cycle pulse, arms delivery of a frame
//            i_wr_valid/i_wr_pixel - HPS pixel write strobe and data
//            o_wr_ready            - FIFO not full
//            i_ready_recieve_pixel - detector can take a pixel (level)
//            i_end_frame           - detector end-of-frame pulse
//            o_pixel               - pixel to the detector (held between pulses)
//            o_end_recieve_pixel   - one-cycle pulse, o_pixel valid
//            o_frame_done          - one-cycle pulse when the frame closes
//            o_pixel_count         - pixels delivered in the current frame
//            o_overflow            - sticky, a write was dropped on a full FIFO
//            o_busy                - controller not idle
// Revision : 1.0 - initial release
// ============================================================================
module pixel_feed_controller #(
  parameter int DATA_WIDTH   = 12,
  parameter int FRAME_WIDTH  = 320,
  parameter int FRAME_HEIGHT = 240,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_WIDTH    = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_wr_pixel,
  output logic                  o_wr_ready,
  input  logic                  i_ready_recieve_pixel,
  input  logic                  i_end_frame,
  output logic [DATA_WIDTH-1:0] o_pixel,
  output logic                  o_end_recieve_pixel,
  output logic                  o_frame_done,
  output logic [CNT_WIDTH-1:0]  o_pixel_count,
  output logic                  o_overflow,
  output logic                  o_busy
);

  // FIFO_DEPTH is a power of two (>= 2), so pointers wrap naturally.
  localparam int ADDR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CNT_WIDTH-1:0]  c_frame_pixels = CNT_WIDTH'(FRAME_WIDTH * FRAME_HEIGHT);
  localparam logic [ADDR_WIDTH:0]   c_fifo_depth   = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one      = ADDR_WIDTH'(1);

  localparam logic [1:0] c_st_idle           = 2'd0;
  localparam logic [1:0] c_st_wait_ready     = 2'd1;
  localparam logic [1:0] c_st_send           = 2'd2;
  localparam logic [1:0] c_st_wait_frame_end = 2'd3;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_pixel;
  logic                  r_end_pulse;
  logic                  r_frame_done;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_level == c_fifo_depth);
  assign w_empty = (r_level == '0);
  assign w_push  = i_wr_valid && !w_full;
  // End of frame takes priority over a pop in WAIT_READY: the frame closes
  // and the head pixel stays queued for the next frame.
  assign w_pop   = (r_state == c_st_wait_ready) && i_ready_recieve_pixel &&
                   !w_empty && !i_end_frame;

  // Storage has no reset; emptiness is defined by the pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Delivery FSM. The pixel, pulse and count are registered on the edge that
  // enters SEND, so all three are visible together during the SEND cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= c_st_idle;
      r_pixel      <= '0;
      r_end_pulse  <= 1'b0;
      r_frame_done <= 1'b0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_end_pulse  <= 1'b0;
      r_frame_done <= 1'b0;

      // Dropped write: judged on the pre-edge fullness, even if a pop
      // frees a slot on this same edge.
      if (i_wr_valid && w_full) begin
        r_overflow <= 1'b1;
      end

      case (r_state)
        c_st_idle: begin
          if (i_start) begin
            r_state <= c_st_wait_ready;
            r_count <= '0;
          end
        end

        c_st_wait_ready: begin
          if (i_end_frame) begin
            r_frame_done <= 1'b1;
            r_state      <= c_st_idle;
          end else if (w_pop) begin
            r_pixel     <= r_mem[r_rd_ptr];
            r_end_pulse <= 1'b1;
            r_count     <= r_count + 1'b1;
            r_state     <= c_st_send;
          end
        end

        c_st_send: begin
          // r_count already holds the incremented value here.
          if (i_end_frame) begin
            r_frame_done <= 1'b1;
            r_state      <= c_st_idle;
          end else if (r_count == c_frame_pixels) begin
            r_state <= c_st_wait_frame_end;
          end else begin
            r_state <= c_st_wait_ready;
          end
        end

        c_st_wait_frame_end: begin
          if (i_end_frame) begin
            r_frame_done <= 1'b1;
            r_state      <= c_st_idle;
          end
        end

        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign o_wr_ready          = !w_full;
  assign o_pixel             = r_pixel;
  assign o_end_recieve_pixel = r_end_pulse;
  assign o_frame_done        = r_frame_done;
  assign o_pixel_count       = r_count;
  assign o_overflow          = r_overflow;
  assign o_busy              = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_pixel_feed_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_feed_controller
// Purpose  : Self-checking bench for pixel_feed_controller with a small frame
//            (4x2) and a 4-entry FIFO. A transaction-level reference model
//            (queue of buffered pixels, frame-armed flag, delivered count)
//            predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_feed_controller;

  localparam int DW    = 12;
  localparam int FW    = 4;
  localparam int FH    = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 17;
  localparam int TOTAL = FW * FH;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic          i_wr_valid;
  logic [DW-1:0] i_wr_pixel;
  logic          o_wr_ready;
  logic          i_ready_recieve_pixel;
  logic          i_end_frame;
  logic [DW-1:0] o_pixel;
  logic          o_end_recieve_pixel;
  logic          o_frame_done;
  logic [CW-1:0] o_pixel_count;
  logic          o_overflow;
  logic          o_busy;

  always #5 clk = ~clk;

  pixel_feed_controller #(
    .DATA_WIDTH  (DW),
    .FRAME_WIDTH (FW),
    .FRAME_HEIGHT(FH),
    .FIFO_DEPTH  (DEPTH),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .i_start              (i_start),
    .i_wr_valid           (i_wr_valid),
    .i_wr_pixel           (i_wr_pixel),
    .o_wr_ready           (o_wr_ready),
    .i_ready_recieve_pixel(i_ready_recieve_pixel),
    .i_end_frame          (i_end_frame),
    .o_pixel              (o_pixel),
    .o_end_recieve_pixel  (o_end_recieve_pixel),
    .o_frame_done         (o_frame_done),
    .o_pixel_count        (o_pixel_count),
    .o_overflow           (o_overflow),
    .o_busy               (o_busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state, describing the controller after the last edge.
  logic [DW-1:0] q[$];
  bit            m_active;
  bit            m_pulse;
  bit            m_done;
  bit            m_ovf;
  int            m_delivered;
  logic [DW-1:0] m_pix;

  // Drive one cycle of inputs, advance the model across the coming edge,
  // then wait for that edge and settle.
  task automatic tick(input bit rst_n, input bit st, input bit wv,
                      input logic [DW-1:0] wd, input bit rd, input bit ef);
    bit full;
    reset                 = rst_n;
    i_start               = st;
    i_wr_valid            = wv;
    i_wr_pixel            = wd;
    i_ready_recieve_pixel = rd;
    i_end_frame           = ef;
    if (!rst_n) begin
      q.delete();
      m_active    = 1'b0;
      m_pulse     = 1'b0;
      m_done      = 1'b0;
      m_ovf       = 1'b0;
      m_delivered = 0;
      m_pix       = '0;
    end else begin
      full   = (q.size() >= DEPTH);
      m_done = m_active && ef;
      // A delivery needs an armed frame, no delivery on the previous cycle,
      // room left in the frame, a ready detector, a queued pixel and no
      // end-of-frame this cycle.
      m_pulse = m_active && !m_pulse && (m_delivered < TOTAL) && rd &&
                (q.size() > 0) && !ef;
      if (m_pulse) begin
        m_pix = q.pop_front();
        m_delivered++;
      end
      if (m_active && ef) begin
        m_active = 1'b0;
      end else if (!m_active && st) begin
        m_active    = 1'b1;
        m_delivered = 0;
      end
      if (wv) begin
        if (full) m_ovf = 1'b1;
        else      q.push_back(wd);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(0, 0, 0, '0, 0, 0);
    tick(0, 0, 0, '0, 0, 0);
    total++;
    if (o_wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_wr_ready got=%b exp=1", o_wr_ready);
    end
    total++;
    if ({o_end_recieve_pixel, o_frame_done, o_overflow, o_busy} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got pulse=%b done=%b ovf=%b busy=%b exp=0000",
               o_end_recieve_pixel, o_frame_done, o_overflow, o_busy);
    end
    total++;
    if (o_pixel !== '0 || o_pixel_count !== '0) begin
      bad++;
      $display("FAIL reset_data got pixel=%h count=%0d exp=0/0", o_pixel, o_pixel_count);
    end
    tick(1, 0, 0, '0, 0, 0);
  endtask

  task automatic test_full_frame();
    int v      = 1;
    int npulse = 0;
    int last_c = 0;
    tick(0, 0, 0, '0, 0, 0);
    for (int c = 0; c < 60 && npulse < TOTAL; c++) begin
      bit wv;
      wv = (v <= TOTAL) && (q.size() < DEPTH);
      tick(1, c == 0, wv, wv ? DW'(v) : '0, 1, 0);
      if (wv) v++;
      if (o_end_recieve_pixel === 1'b1) begin
        npulse++;
        total++;
        if (o_pixel !== DW'(npulse)) begin
          bad++;
          $display("FAIL frame_pixel got=%0d exp=%0d", o_pixel, npulse);
        end
        if (npulse > 1) begin
          total++;
          if (c - last_c != 2) begin
            bad++;
            $display("FAIL frame_spacing got=%0d exp=2", c - last_c);
          end
        end
        last_c = c;
      end
    end
    total++;
    if (npulse != TOTAL) begin
      bad++;
      $display("FAIL frame_pulses got=%0d exp=%0d", npulse, TOTAL);
    end
    tick(1, 0, 0, '0, 1, 0);
    tick(1, 0, 0, '0, 1, 0);
    total++;
    if (o_pixel_count !== CW'(TOTAL) || o_busy !== 1'b1 ||
        o_end_recieve_pixel !== 1'b0 || o_pixel !== DW'(TOTAL)) begin
      bad++;
      $display("FAIL frame_wait_end got count=%0d busy=%b pulse=%b pixel=%0d exp=%0d/1/0/%0d",
               o_pixel_count, o_busy, o_end_recieve_pixel, o_pixel, TOTAL, TOTAL);
    end
    tick(1, 0, 0, '0, 1, 1);
    total++;
    if (o_frame_done !== 1'b1 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL frame_done got done=%b busy=%b exp=1/0", o_frame_done, o_busy);
    end
    tick(1, 0, 0, '0, 1, 0);
    total++;
    if (o_frame_done !== 1'b0) begin
      bad++;
      $display("FAIL frame_done_width got=%b exp=0", o_frame_done);
    end
  endtask

  task automatic test_overflow();
    tick(0, 0, 0, '0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      tick(1, 0, 1, DW'(12'h100 + k), 0, 0);
      total++;
      if (o_wr_ready !== (k < DEPTH) || o_overflow !== (k > DEPTH)) begin
        bad++;
        $display("FAIL overflow_write%0d got ready=%b ovf=%b exp=%b/%b",
                 k, o_wr_ready, o_overflow, k < DEPTH, k > DEPTH);
      end
    end
    for (int k = 0; k < 3; k++) tick(1, 0, 0, '0, 0, 0);
    total++;
    if (o_overflow !== 1'b1 || o_wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL overflow_sticky got ovf=%b ready=%b exp=1/0", o_overflow, o_wr_ready);
    end
  endtask

  task automatic test_empty_start();
    int  npulse = 0;
    bit  found  = 1'b0;
    tick(0, 0, 0, '0, 0, 0);
    tick(1, 1, 0, '0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      tick(1, 0, 0, '0, 1, 0);
      if (o_end_recieve_pixel === 1'b1) npulse++;
    end
    total++;
    if (npulse != 0 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL empty_start_idle got pulses=%0d busy=%b exp=0/1", npulse, o_busy);
    end
    tick(1, 0, 1, 12'hABC, 1, 0);
    for (int k = 0; k < 3 && !found; k++) begin
      tick(1, 0, 0, '0, 1, 0);
      if (o_end_recieve_pixel === 1'b1) found = 1'b1;
    end
    total++;
    if (!found || o_pixel !== 12'hABC) begin
      bad++;
      $display("FAIL empty_start_abc got found=%b pixel=%h exp=1/abc", found, o_pixel);
    end
  endtask

  task automatic test_ready_stall();
    int npulse = 0;
    for (int k = 0; k < 3; k++) begin
      tick(1, 0, 1, DW'(12'h300 + k), 0, 0);
      if (o_end_recieve_pixel === 1'b1) npulse++;
    end
    for (int k = 0; k < 10; k++) begin
      tick(1, 0, 0, '0, 0, 0);
      if (o_end_recieve_pixel === 1'b1) npulse++;
    end
    total++;
    if (npulse != 0) begin
      bad++;
      $display("FAIL stall_no_pulse got=%0d exp=0", npulse);
    end
    for (int k = 0; k < 12 && npulse < 3; k++) begin
      tick(1, 0, 0, '0, 1, 0);
      if (o_end_recieve_pixel === 1'b1) begin
        total++;
        if (o_pixel !== DW'(12'h300 + npulse)) begin
          bad++;
          $display("FAIL stall_pixel got=%h exp=%h", o_pixel, 12'h300 + npulse);
        end
        npulse++;
      end
    end
    total++;
    if (npulse != 3 || o_pixel_count !== CW'(4)) begin
      bad++;
      $display("FAIL stall_release got pulses=%0d count=%0d exp=3/4", npulse, o_pixel_count);
    end
  endtask

  task automatic test_early_end();
    int npulse = 0;
    tick(0, 0, 0, '0, 0, 0);
    tick(1, 1, 1, 12'h010, 1, 0);
    tick(1, 0, 1, 12'h011, 1, 0);
    if (o_end_recieve_pixel === 1'b1) npulse++;
    tick(1, 0, 1, 12'h012, 1, 0);
    if (o_end_recieve_pixel === 1'b1) npulse++;
    for (int k = 0; k < 20 && npulse < 3; k++) begin
      tick(1, 0, 0, '0, 1, 0);
      if (o_end_recieve_pixel === 1'b1) npulse++;
    end
    total++;
    if (npulse != 3) begin
      bad++;
      $display("FAIL early_deliveries got=%0d exp=3", npulse);
    end
    tick(1, 0, 0, '0, 1, 1);
    total++;
    if (o_frame_done !== 1'b1 || o_busy !== 1'b0 || o_pixel_count !== CW'(3)) begin
      bad++;
      $display("FAIL early_end got done=%b busy=%b count=%0d exp=1/0/3",
               o_frame_done, o_busy, o_pixel_count);
    end
    for (int k = 0; k < 3; k++) tick(1, 0, 0, '0, 1, 1);
    total++;
    if (o_frame_done !== 1'b0 || o_pixel_count !== CW'(3)) begin
      bad++;
      $display("FAIL early_hold got done=%b count=%0d exp=0/3", o_frame_done, o_pixel_count);
    end
    tick(1, 1, 0, '0, 0, 0);
    total++;
    if (o_pixel_count !== '0 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL early_restart got count=%0d busy=%b exp=0/1", o_pixel_count, o_busy);
    end
  endtask

  task automatic test_reset_in_send();
    bit in_send = 1'b0;
    int npulse  = 0;
    tick(0, 0, 0, '0, 0, 0);
    for (int k = 0; k < 3; k++) tick(1, 0, 1, DW'(12'h0A0 + k), 0, 0);
    tick(1, 1, 0, '0, 1, 0);
    for (int k = 0; k < 5 && !in_send; k++) begin
      tick(1, 0, 0, '0, 1, 0);
      if (o_end_recieve_pixel === 1'b1) in_send = 1'b1;
    end
    total++;
    if (!in_send) begin
      bad++;
      $display("FAIL rst_send_reach got=0 exp=1");
    end
    tick(0, 0, 0, '0, 1, 0);
    total++;
    if (o_end_recieve_pixel !== 1'b0 || o_pixel_count !== '0 || o_frame_done !== 1'b0 ||
        o_wr_ready !== 1'b1 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_send_state got pulse=%b count=%0d done=%b ready=%b busy=%b exp=0/0/0/1/0",
               o_end_recieve_pixel, o_pixel_count, o_frame_done, o_wr_ready, o_busy);
    end
    tick(1, 0, 0, '0, 1, 0);
    total++;
    if (o_frame_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_send_done got=%b exp=0", o_frame_done);
    end
    tick(1, 1, 0, '0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      tick(1, 0, 0, '0, 1, 0);
      if (o_end_recieve_pixel === 1'b1) npulse++;
    end
    total++;
    if (npulse != 0) begin
      bad++;
      $display("FAIL rst_send_fifo_empty got pulses=%0d exp=0", npulse);
    end
  endtask

  task automatic test_random();
    tick(0, 0, 0, '0, 0, 0);
    for (int c = 0; c < 1500; c++) begin
      bit rst_n;
      bit st;
      bit wv;
      bit rd;
      bit ef;
      rst_n = ($urandom_range(0, 199) != 0);
      st    = ($urandom_range(0, 9) == 0);
      wv    = ($urandom_range(0, 1) == 1);
      rd    = ($urandom_range(0, 9) < 7);
      ef    = ($urandom_range(0, 39) == 0);
      tick(rst_n, st, wv, DW'($urandom), rd, ef);
      total++;
      if (o_end_recieve_pixel !== m_pulse || o_frame_done !== m_done ||
          o_busy !== m_active || o_overflow !== m_ovf ||
          o_wr_ready !== (q.size() < DEPTH)) begin
        bad++;
        $display("FAIL rand_ctrl cyc=%0d got pulse=%b done=%b busy=%b ovf=%b ready=%b exp=%b/%b/%b/%b/%b",
                 c, o_end_recieve_pixel, o_frame_done, o_busy, o_overflow, o_wr_ready,
                 m_pulse, m_done, m_active, m_ovf, q.size() < DEPTH);
      end
      total++;
      if (o_pixel !== m_pix || o_pixel_count !== CW'(m_delivered)) begin
        bad++;
        $display("FAIL rand_data cyc=%0d got pixel=%h count=%0d exp=%h/%0d",
                 c, o_pixel, o_pixel_count, m_pix, m_delivered);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_overflow();
    test_empty_start();
    test_ready_stall();
    test_early_end();
    test_reset_in_send();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
